// File: rtl/balu_issue.sv
// Issue stage ahead of the BALU bit-manipulation unit: decodes Zbs/Zbb ops to
// BALU mode codes, registers operands, and runs CPOP with an iterative counter.
module balu_issue #(
  parameter int unsigned CPOP_STEP = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] balu_num1,
  output logic [31:0] balu_num2,
  output logic [7:0]  balu_mode,
  input  logic [31:0] balu_ans,
  input  logic        balu_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam int unsigned NSTEPS = 32 / CPOP_STEP;

  localparam logic [7:0] M_BCLR = 8'h30;
  localparam logic [7:0] M_BEXT = 8'h31;
  localparam logic [7:0] M_BINV = 8'h32;
  localparam logic [7:0] M_BSET = 8'h33;
  localparam logic [7:0] M_CLZ  = 8'h34;
  localparam logic [7:0] M_CPOP = 8'h35;
  localparam logic [7:0] M_CTZ  = 8'h36;
  localparam logic [7:0] M_ROL  = 8'h37;
  localparam logic [7:0] M_ROR  = 8'h38;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CPOP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] num1_q, num1_d;
  logic [31:0] num2_q, num2_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] out_data_q, out_data_d;
  logic [7:0]  mode_q, mode_d;
  logic [4:0]  rd_q, rd_d;
  logic        illegal_q, illegal_d;
  logic        out_illegal_q, out_illegal_d;
  logic [5:0]  acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs2f;
  logic        is_r, is_i;
  logic [7:0]  dec_mode;
  logic [31:0] dec_num2;
  logic [5:0]  chunk_cnt, acc_sum;
  logic [4:0]  unused_rs1_field;

  assign opc              = instr[6:0];
  assign f3               = instr[14:12];
  assign rs2f             = instr[24:20];
  assign f7               = instr[31:25];
  assign unused_rs1_field = instr[19:15];
  assign is_r             = (opc == 7'b0110011);
  assign is_i             = (opc == 7'b0010011);

  always_comb begin
    dec_mode = '0;
    dec_num2 = is_i ? {27'b0, rs2f} : rs2_data;
    if (is_r || is_i) begin
      case ({f7, f3})
        {7'b0100100, 3'b001}: dec_mode = M_BCLR;
        {7'b0100100, 3'b101}: dec_mode = M_BEXT;
        {7'b0110100, 3'b001}: dec_mode = M_BINV;
        {7'b0010100, 3'b001}: dec_mode = M_BSET;
        {7'b0110000, 3'b101}: dec_mode = M_ROR;
        {7'b0110000, 3'b001}: begin
          // Same funct7/funct3 is ROL for R-type but the unary count ops for I-type
          if (is_r) begin
            dec_mode = M_ROL;
          end else begin
            case (rs2f)
              5'd0:    dec_mode = M_CLZ;
              5'd1:    dec_mode = M_CTZ;
              5'd2:    dec_mode = M_CPOP;
              default: dec_mode = '0;
            endcase
          end
        end
        default: dec_mode = '0;
      endcase
    end
  end

  always_comb begin
    chunk_cnt = '0;
    for (int unsigned i = 0; i < CPOP_STEP; i++) begin
      chunk_cnt = chunk_cnt + {5'b0, shift_q[i[4:0]]};
    end
    acc_sum = acc_q + chunk_cnt;
  end

  always_comb begin
    state_d       = state_q;
    num1_d        = num1_q;
    num2_d        = num2_q;
    shift_d       = shift_q;
    mode_d        = mode_q;
    rd_d          = rd_q;
    illegal_d     = illegal_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_illegal_d = out_illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          num1_d    = rs1_data;
          num2_d    = dec_num2;
          shift_d   = rs1_data;
          mode_d    = dec_mode;
          rd_d      = instr[11:7];
          illegal_d = (dec_mode == 8'h00);
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = (dec_mode == M_CPOP) ? S_CPOP : S_EXEC;
        end
      end
      S_EXEC: begin
        out_data_d    = illegal_q ? '0 : balu_ans;
        out_illegal_d = illegal_q | balu_error;
        state_d       = S_DONE;
      end
      S_CPOP: begin
        acc_d   = acc_sum;
        shift_d = shift_q >> CPOP_STEP;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'(NSTEPS - 1)) begin
          out_data_d    = {26'b0, acc_sum};
          out_illegal_d = 1'b0;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      num1_q        <= '0;
      num2_q        <= '0;
      shift_q       <= '0;
      mode_q        <= '0;
      rd_q          <= '0;
      illegal_q     <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      num1_q        <= num1_d;
      num2_q        <= num2_d;
      shift_q       <= shift_d;
      mode_q        <= mode_d;
      rd_q          <= rd_d;
      illegal_q     <= illegal_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign balu_num1   = num1_q;
  assign balu_num2   = num2_q;
  assign balu_mode   = mode_q;
  assign out_data    = out_data_q;
  assign out_rd      = rd_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_balu_issue.sv
// Randomized scoreboard bench for balu_issue with a behavioural BALU stand-in
// and an instruction-level reference model.
module tb_balu_issue;

  localparam int unsigned STEP0 = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready;
  logic [31:0] instr, rs1_data, rs2_data;
  logic [31:0] balu_num1, balu_num2, balu_ans;
  logic [7:0]  balu_mode;
  logic        balu_error;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  logic        s_in_valid, s_in_ready;
  logic [31:0] s_instr, s_rs1_data, s_rs2_data;
  logic [31:0] s_balu_num1, s_balu_num2, s_balu_ans;
  logic [7:0]  s_balu_mode;
  logic        s_balu_error;
  logic        s_out_valid, s_out_ready, s_out_illegal;
  logic [31:0] s_out_data;
  logic [4:0]  s_out_rd;

  always #5 clk = ~clk;

  balu_issue #(.CPOP_STEP(STEP0)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .balu_num1(balu_num1), .balu_num2(balu_num2), .balu_mode(balu_mode),
    .balu_ans(balu_ans), .balu_error(balu_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  balu_issue #(.CPOP_STEP(1)) u_dut_s1 (
    .clk(clk), .rstn(rstn), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .instr(s_instr), .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
    .balu_num1(s_balu_num1), .balu_num2(s_balu_num2), .balu_mode(s_balu_mode),
    .balu_ans(s_balu_ans), .balu_error(s_balu_error),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_rd(s_out_rd), .out_illegal(s_out_illegal)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        illegal;
    logic [7:0]  mode;
    logic [31:0] num1;
    logic [31:0] num2;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          hold_cnt = 0;
  bit          rand_bp = 1'b0;
  logic        err_inj = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clz32(input logic [31:0] a);
    for (int i = 31; i >= 0; i--) if (a[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int ctz32(input logic [31:0] a);
    for (int i = 0; i < 32; i++) if (a[i]) return i;
    return 32;
  endfunction

  // Behavioural BALU: what the downstream unit computes for each mode code
  function automatic logic [31:0] balu_fn(input logic [7:0] m, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] dbl;
    logic [31:0] bit1;
    dbl  = {a, a};
    bit1 = 32'd1 << b[4:0];
    case (m)
      8'h30: return a & ~bit1;
      8'h31: return (a >> b[4:0]) & 32'd1;
      8'h32: return a ^ bit1;
      8'h33: return a | bit1;
      8'h34: return 32'(clz32(a));
      8'h36: return 32'(ctz32(a));
      8'h37: begin dbl = dbl << b[4:0]; return dbl[63:32]; end
      8'h38: begin dbl = dbl >> b[4:0]; return dbl[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    balu_ans     = balu_fn(balu_mode, balu_num1, balu_num2);
    balu_error   = err_inj;
    s_balu_ans   = balu_fn(s_balu_mode, s_balu_num1, s_balu_num2);
    s_balu_error = 1'b0;
  end

  function automatic logic [7:0] ref_mode(input logic [31:0] ins);
    logic       r, i;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] sh;
    r  = (ins[6:0] == 7'h33);
    i  = (ins[6:0] == 7'h13);
    f7 = ins[31:25];
    f3 = ins[14:12];
    sh = ins[24:20];
    if (!(r || i)) return 8'h00;
    if (f7 == 7'b0100100 && f3 == 3'd1) return 8'h30;
    if (f7 == 7'b0100100 && f3 == 3'd5) return 8'h31;
    if (f7 == 7'b0110100 && f3 == 3'd1) return 8'h32;
    if (f7 == 7'b0010100 && f3 == 3'd1) return 8'h33;
    if (f7 == 7'b0110000 && f3 == 3'd5) return 8'h38;
    if (r && f7 == 7'b0110000 && f3 == 3'd1) return 8'h37;
    if (i && f7 == 7'b0110000 && f3 == 3'd1 && sh == 5'd0) return 8'h34;
    if (i && f7 == 7'b0110000 && f3 == 3'd1 && sh == 5'd1) return 8'h36;
    if (i && f7 == 7'b0110000 && f3 == 3'd1 && sh == 5'd2) return 8'h35;
    return 8'h00;
  endfunction

  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b, input logic err, input int acc);
    exp_t e;
    e.mode    = ref_mode(ins);
    e.rd      = ins[11:7];
    e.num1    = a;
    e.num2    = (ins[6:0] == 7'h13) ? {27'b0, ins[24:20]} : b;
    e.acc_cyc = acc;
    if (e.mode == 8'h35) begin
      e.data    = 32'($countones(a));
      e.illegal = 1'b0;
      e.lat     = 1 + 32 / STEP0;
    end else begin
      e.illegal = (e.mode == 8'h00) | err;
      e.data    = (e.mode == 8'h00) ? 32'h0 : balu_fn(e.mode, a, e.num2);
      e.lat     = 2;
    end
    return e;
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2f,
                                      input logic [4:0] rs1f, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2f, rs1f, f3, rd, opc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input logic err, input bit push);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL in_ready_timeout: in_ready stuck at 0, required 1");
      return;
    end
    instr    = ins;
    rs1_data = a;
    rs2_data = b;
    err_inj  = err;
    in_valid = 1'b1;
    if (push) exp_q.push_back(ref_model(ins, a, b, err, cyc));
    @(negedge clk);
    in_valid = 1'b0;
    instr    = $urandom;
    rs1_data = $urandom;
    rs2_data = $urandom;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !in_ready) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0 || !in_ready) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic rand_op(output logic [31:0] ins);
    logic [6:0] opc;
    logic [4:0] sh, rs1f, rd;
    int unsigned k;
    opc  = $urandom_range(0, 1) ? 7'h33 : 7'h13;
    sh   = 5'($urandom);
    rs1f = 5'($urandom);
    rd   = 5'($urandom);
    k    = $urandom_range(0, 10);
    case (k)
      0: ins = enc(7'b0100100, sh, rs1f, 3'd1, rd, opc);
      1: ins = enc(7'b0100100, sh, rs1f, 3'd5, rd, opc);
      2: ins = enc(7'b0110100, sh, rs1f, 3'd1, rd, opc);
      3: ins = enc(7'b0010100, sh, rs1f, 3'd1, rd, opc);
      4: ins = enc(7'b0110000, 5'd0, rs1f, 3'd1, rd, 7'h13);
      5: ins = enc(7'b0110000, 5'd1, rs1f, 3'd1, rd, 7'h13);
      6: ins = enc(7'b0110000, 5'd2, rs1f, 3'd1, rd, 7'h13);
      7: ins = enc(7'b0110000, sh, rs1f, 3'd1, rd, 7'h33);
      8: ins = enc(7'b0110000, sh, rs1f, 3'd5, rd, opc);
      9: ins = $urandom;
      default: ins = enc(7'b0110000, 5'd3, rs1f, 3'd1, rd, 7'h13);
    endcase
  endtask

  // Monitor: pops one expectation per out_valid rise and checks hold-stability after
  initial begin
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          if (!prev_v) begin
            if (exp_q.size() == 0) begin
              n_total++;
              $display("FAIL unexpected_output: out_valid=1 with data 0x%08h, required no output", out_data);
            end else begin
              cur = exp_q.pop_front();
              check("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
              check("out_data", out_data, cur.data);
              check("out_rd", {27'b0, out_rd}, {27'b0, cur.rd});
              check("out_illegal", {31'b0, out_illegal}, {31'b0, cur.illegal});
              check("balu_mode", {24'b0, balu_mode}, {24'b0, cur.mode});
              check("balu_num1", balu_num1, cur.num1);
              check("balu_num2", balu_num2, cur.num2);
            end
          end else begin
            check("hold_data", out_data, cur.data);
            check("hold_rd", {27'b0, out_rd}, {27'b0, cur.rd});
            check("hold_illegal", {31'b0, out_illegal}, {31'b0, cur.illegal});
          end
          check("in_ready_in_done", {31'b0, in_ready}, 32'h0);
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, a, b;
    int          acc;
    rstn       = 1'b0;
    in_valid   = 1'b0;
    instr      = '0;
    rs1_data   = '0;
    rs2_data   = '0;
    out_ready  = 1'b1;
    s_in_valid = 1'b0;
    s_instr    = '0;
    s_rs1_data = '0;
    s_rs2_data = '0;
    s_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_balu_mode", {24'b0, balu_mode}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_rd", {27'b0, out_rd}, 32'h0);
    check("rst_out_illegal", {31'b0, out_illegal}, 32'h0);
    check("rst_balu_num1", balu_num1, 32'h0);
    check("rst_balu_num2", balu_num2, 32'h0);

    send(32'h28511093, 32'h0, $urandom, 1'b0, 1'b1);
    send(enc(7'b0110000, 5'd0, 5'd2, 3'd1, 5'd3, 7'h13), 32'h00010000, 32'h0, 1'b0, 1'b1);
    send(enc(7'b0110000, 5'd1, 5'd2, 3'd1, 5'd4, 7'h13), 32'h0, 32'h0, 1'b0, 1'b1);
    send(enc(7'b0110000, 5'd3, 5'd2, 3'd5, 5'd5, 7'h33), 32'h1, 32'h1, 1'b0, 1'b1);
    send(enc(7'b0100100, 5'd3, 5'd2, 3'd5, 5'd6, 7'h33), 32'h8, 32'h3, 1'b0, 1'b1);
    send(32'h00000013, 32'h12345678, 32'h0, 1'b0, 1'b1);
    send(enc(7'b0010100, 5'd7, 5'd2, 3'd1, 5'd8, 7'h13), 32'h0, 32'h0, 1'b1, 1'b1);

    wait_idle();
    send(enc(7'b0110000, 5'd2, 5'd1, 3'd1, 5'd9, 7'h13), 32'hF0F00001, 32'h0, 1'b0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      check("cpop_in_ready_low", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
    end

    // Backpressure with in_valid asserted while busy
    wait_idle();
    hold_cnt = 7;
    send(enc(7'b0110100, 5'd0, 5'd1, 3'd1, 5'd10, 7'h33), 32'hFF, 32'h0, 1'b0, 1'b1);
    instr    = 32'h00000013;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;

    // Reset in the middle of a CPOP discards it
    wait_idle();
    send(enc(7'b0110000, 5'd2, 5'd1, 3'd1, 5'd11, 7'h13), 32'hF0F00001, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_out_rd", {27'b0, out_rd}, 32'h0);
    check("mid_rst_balu_num1", balu_num1, 32'h0);
    check("mid_rst_balu_mode", {24'b0, balu_mode}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'h0);
    send(enc(7'b0110100, 5'd0, 5'd1, 3'd1, 5'd12, 7'h33), 32'hFF, 32'h0, 1'b0, 1'b1);

    rand_bp = 1'b1;
    for (int n = 0; n < 60; n++) begin
      rand_op(ins);
      a = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      b = $urandom;
      send(ins, a, b, ($urandom_range(0, 7) == 0), 1'b1);
    end
    wait_idle();
    rand_bp = 1'b0;

    // Single-bit-per-cycle CPOP variant
    @(negedge clk);
    s_instr    = enc(7'b0110000, 5'd2, 5'd1, 3'd1, 5'd13, 7'h13);
    s_rs1_data = 32'hF0F00001;
    s_in_valid = 1'b1;
    acc = cyc;
    @(negedge clk);
    s_in_valid = 1'b0;
    while (!s_out_valid && (cyc - acc) < 100) @(negedge clk);
    check("s1_cpop_latency", 32'(cyc - acc), 32'd33);
    check("s1_cpop_data", s_out_data, 32'd9);
    check("s1_cpop_rd", {27'b0, s_out_rd}, 32'd13);
    check("s1_cpop_illegal", {31'b0, s_out_illegal}, 32'h0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/balu_issue.md
# balu_issue

Issue/sequencing stage directly upstream of the BALU bit-manipulation unit in the RV32 execute path. Accepts a decoded-stage instruction plus register operands over a valid/ready handshake, maps Zbs/Zbb bit instructions to BALU mode codes, drives BALU's combinational inputs from registered operands, and returns a registered result with destination register. Computes CPOP itself with a multi-cycle iterative counter, since BALU has no population-count path.

## Interface
- CPOP_STEP, 4, bits examined per CPOP cycle; legal values are 1, 2, 4, 8, 16, 32; CPOP takes 32/CPOP_STEP cycles.
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instruction and operands valid.
- in_ready  out  1  stage can accept; high only in IDLE.
- instr  in  32  RV32 instruction word.
- rs1_data  in  32  rs1 operand.
- rs2_data  in  32  rs2 operand; used only for R-type.
- balu_num1  out  32  BALU num1 = registered rs1.
- balu_num2  out  32  BALU num2 = registered rs2 or zero-extended shamt.
- balu_mode  out  8  BALU mode_sel.
- balu_ans  in  32  BALU ans.
- balu_error  in  1  BALU error.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  result.
- out_rd  out  5  destination register, instr[11:7].
- out_illegal  out  1  instruction not a supported bit op, or BALU flagged an error.

## Operation
- Decode. R-type uses opcode 0110011. I-type uses opcode 0010011 and takes num2 = {27'b0, instr[24:20]}.
  - BCLR 0x30: funct7 0100100, funct3 001. R and I forms.
  - BEXT 0x31: funct7 0100100, funct3 101. R and I forms.
  - BINV 0x32: funct7 0110100, funct3 001. R and I forms.
  - BSET 0x33: funct7 0010100, funct3 001. R and I forms.
  - CLZ 0x34: I-opcode, funct7 0110000, funct3 001, rs2 field 00000.
  - CTZ 0x36: as CLZ, rs2 field 00001.
  - CPOP 0x35: as CLZ, rs2 field 00010.
  - ROL 0x37: R-type, funct7 0110000, funct3 001.
  - ROR 0x38: R-type, funct7 0110000, funct3 101, or I-type (RORI) with the same fields.
  - Anything else is illegal; mode register 0x00.
- State machine, states IDLE, EXEC, CPOP, DONE.
  - IDLE: on in_valid && in_ready, latch num1, num2, mode, rd and the illegal flag. Go to CPOP if mode = 0x35 and legal, else EXEC.
  - EXEC: BALU sees the registered inputs for one full cycle. At the clock edge:
    - out_data = illegal ? 0 : balu_ans.
    - out_illegal = illegal | balu_error.
    - Go to DONE.
  - CPOP: each cycle, add popcount(shift[CPOP_STEP-1:0]) to a 6-bit accumulator and shift right by CPOP_STEP. A step counter runs 0 .. 32/CPOP_STEP-1. On the last step, load out_data = {26'b0, acc + final chunk}, set out_illegal = 0, go to DONE. balu_mode is driven 0x35 during CPOP and balu_ans/balu_error are ignored.
  - DONE: out_valid = 1. On out_ready, go to IDLE. out_data, out_rd and out_illegal hold stable while waiting.
- balu_num1, balu_num2 and balu_mode always reflect the operand registers; all are zero in reset/IDLE after reset.
- Reset (async, any state): state IDLE; all registers, out_valid, out_data, out_rd, out_illegal, balu_* = 0; CPOP accumulator and counter cleared. An in-flight instruction is discarded, with no output.

## Timing
- Accept edge = cycle 0.
- Non-CPOP: out_valid rises cycle 2 (latency 2). Peak throughput is one op per 3 cycles with out_ready held high.
- CPOP: out_valid rises cycle 1 + 32/CPOP_STEP (cycle 9 at default).
- in_ready = (state == IDLE). It is combinational from state only, with no dependency on in_valid or out_ready.
- out_valid falls the cycle after the out_ready handshake edge. A new instruction can be accepted on the cycle in_ready returns high.
- No combinational path from instr or rs*_data to outputs; BALU feeds only the result registers.

## Test plan
- BSETI x1,x2,5 (0x28511093), rs1 = 0 -> out_valid at cycle 2, out_data = 0x00000020, out_rd = 1, out_illegal = 0.
- CLZ rs1 = 0x00010000 -> out_data = 15. CTZ rs1 = 0 -> 32. ROR rs1 = 0x1, rs2 = 1 -> 0x80000000. BEXT rs1 = 0x8, rs2 = 3 -> 1.
- CPOP rs1 = 0xF0F00001 -> out_valid first at cycle 9, out_data = 9, in_ready low cycles 1-9. Repeat with CPOP_STEP = 1 -> valid at cycle 33.
- Backpressure: hold out_ready low 4 cycles after out_valid -> out_data and out_rd stable, in_ready low, in_valid ignored. out_ready high -> IDLE next cycle.
- Illegal: ADDI 0x00000013 -> out_valid at cycle 2, out_illegal = 1, out_data = 0.
- Assert rstn low in cycle 4 of a CPOP -> all outputs 0 immediately. After release, in_ready = 1 and no stale out_valid. A following BINV rs1 = 0xFF, rs2 = 0 -> 0xFE.
